// File: rtl/bus_router_pkg.sv
// Shared constants for the bus router: device indices in decoder output order,
// FSM encodings and the read data returned on a failed access.
package bus_router_pkg;

  localparam int unsigned N_DEV = 13;

  // Bit positions in the decoder's one-hot select vector
  localparam int unsigned DEV_BOOT    = 0;
  localparam int unsigned DEV_UART    = 1;
  localparam int unsigned DEV_GPIO    = 2;
  localparam int unsigned DEV_TIMER   = 3;
  localparam int unsigned DEV_SPI     = 4;
  localparam int unsigned DEV_I2C     = 5;
  localparam int unsigned DEV_PWM     = 6;
  localparam int unsigned DEV_ADC     = 7;
  localparam int unsigned DEV_DMA     = 8;
  localparam int unsigned DEV_SRAM    = 9;
  localparam int unsigned DEV_SDRAM   = 10;
  localparam int unsigned DEV_VIDEO   = 11;
  localparam int unsigned DEV_SYNTH16 = 12;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StErr  = 2'd2;

  localparam logic [31:0] BUS_ERR_RDATA = 32'h0;

  // Index width for an n-entry select vector; never zero so a 1-device build still elaborates
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_router_if.sv
// CPU-side and device-side signal bundle of the bus router.
// slave is the router's view; master is the CPU/decoder/device side.
interface bus_router_if #(
  parameter int unsigned N_DEV = 13
);

  logic                  i_req;
  logic                  i_we;
  logic [31:0]           i_address;
  logic [31:0]           i_wdata;
  logic [3:0]            i_byte_en;
  logic [N_DEV-1:0]      i_sel;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_bus_error;
  logic [31:0]           o_rdata;
  logic [N_DEV-1:0]      o_dev_req;
  logic                  o_dev_we;
  logic [31:0]           o_dev_addr;
  logic [31:0]           o_dev_wdata;
  logic [3:0]            o_dev_be;
  logic [N_DEV-1:0]      i_dev_done;
  logic [N_DEV*32-1:0]   i_dev_rdata;

  modport slave (
    input  i_req, i_we, i_address, i_wdata, i_byte_en, i_sel, i_dev_done, i_dev_rdata,
    output o_busy, o_done, o_bus_error, o_rdata, o_dev_req, o_dev_we, o_dev_addr,
           o_dev_wdata, o_dev_be
  );

  modport master (
    output i_req, i_we, i_address, i_wdata, i_byte_en, i_sel, i_dev_done, i_dev_rdata,
    input  o_busy, o_done, o_bus_error, o_rdata, o_dev_req, o_dev_we, o_dev_addr,
           o_dev_wdata, o_dev_be
  );

endinterface

// File: rtl/bus_router_onehot_encoder.sv
// Converts a one-hot select vector into a binary index; onehot_ok_o is low when
// no bit or more than one bit is set (index is then meaningless).
module bus_router_onehot_encoder
  import bus_router_pkg::*;
#(
  parameter int unsigned N    = 13,
  parameter int unsigned IdxW = idx_width(N)
) (
  input  logic [N-1:0]    sel_i,
  output logic [IdxW-1:0] idx_o,
  output logic            onehot_ok_o
);

  logic any_hit;
  logic multi_hit;

  always_comb begin
    idx_o     = '0;
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel_i[i]) begin
        // OR-ing indices is exact for one-hot input; the ok flag covers the rest
        idx_o     = idx_o | IdxW'(i);
        multi_hit = multi_hit | any_hit;
        any_hit   = 1'b1;
      end
    end
    onehot_ok_o = any_hit & ~multi_hit;
  end

endmodule

// File: rtl/bus_router.sv
// Transaction sequencer behind the address decoder: forwards one CPU access to the
// selected device, waits for its done pulse or a timeout, and returns data/error.
module bus_router
  import bus_router_pkg::*;
#(
  parameter int unsigned N_DEV          = bus_router_pkg::N_DEV,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input logic          i_clk,
  input logic          i_rst_n,
  bus_router_if.slave  bus
);

  localparam int unsigned     IdxW        = idx_width(N_DEV);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [N_DEV-1:0] dev_req_q, dev_req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [IdxW-1:0]  sel_idx;
  logic             sel_ok;
  logic [31:0]      dev_rdata_sel;
  logic             dev_done_sel;

  bus_router_onehot_encoder #(
    .N    (N_DEV),
    .IdxW (IdxW)
  ) u_onehot_encoder (
    .sel_i       (bus.i_sel),
    .idx_o       (sel_idx),
    .onehot_ok_o (sel_ok)
  );

  // Only the latched device's done/rdata lane is observed; strays are invisible
  always_comb begin
    dev_rdata_sel = '0;
    dev_done_sel  = 1'b0;
    for (int unsigned k = 0; k < N_DEV; k++) begin
      if (idx_q == IdxW'(k)) begin
        dev_rdata_sel = bus.i_dev_rdata[32*k +: 32];
        dev_done_sel  = bus.i_dev_done[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dev_req_d = dev_req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = BUS_ERR_RDATA;

    case (state_q)
      StIdle: begin
        if (bus.i_req) begin
          we_d    = bus.i_we;
          addr_d  = bus.i_address;
          wdata_d = bus.i_wdata;
          be_d    = bus.i_byte_en;
          idx_d   = sel_idx;
          cnt_d   = '0;
          if (sel_ok) begin
            dev_req_d = bus.i_sel;
            state_d   = StWait;
          end else begin
            state_d   = StErr;
          end
        end
      end

      StWait: begin
        // Done is tested first so a completion on the timeout cycle still succeeds
        if (dev_done_sel) begin
          done_d    = 1'b1;
          rdata_d   = we_q ? 32'h0 : dev_rdata_sel;
          dev_req_d = '0;
          cnt_d     = '0;
          state_d   = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          done_d    = 1'b1;
          err_d     = 1'b1;
          dev_req_d = '0;
          cnt_d     = '0;
          state_d   = StIdle;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      StErr: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = StIdle;
      end

      default: begin
        dev_req_d = '0;
        cnt_d     = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      dev_req_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dev_req_q <= dev_req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.o_busy      = (state_q != StIdle);
  assign bus.o_done      = done_q;
  assign bus.o_bus_error = err_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_dev_req   = dev_req_q;
  assign bus.o_dev_we    = we_q;
  assign bus.o_dev_addr  = addr_q;
  assign bus.o_dev_wdata = wdata_q;
  assign bus.o_dev_be    = be_q;

  // A finished transaction must already have released its device request
  a_done_excl_req: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    done_q |-> (dev_req_q == '0));

  a_req_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(dev_req_q));

endmodule
